// File: rtl/uart_msg_scheduler.sv
// uart_msg_scheduler: round-robin arbiter for three message requesters (ID, PICK,
// DUMP) that frames the granted message and streams it byte by byte into the
// UART TX engine over a valid/ready handshake.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   id_req/pick_req/dump_req    1-cycle request pulses
//   node_char                   ASCII node code, latched with any request
//   zone_char                   ASCII zone code, latched with dump_req only
//   tx_data, tx_valid, tx_ready byte stream to the TX engine
//   busy                        high while in ARB, SEND or GAP
//   cur_msg                     message in flight: 0 none, 1 ID, 2 PICK, 3 DUMP
//   msg_done                    pulse after the final byte transfers
//   req_merged                  pulse when a request hits an already-pending one
//
// Parameters: UNIT_CHAR (unit digit in every message), GAP_CYCLES (idle cycles
// between messages, 0 = back-to-back).
// Optional feature macro: UART_NULL_TERM_EN appends an 8'h00 after '#'.

module uart_msg_scheduler #(
  parameter logic [7:0]  UNIT_CHAR  = 8'h32,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_req,
  input  logic       pick_req,
  input  logic       dump_req,
  input  logic [7:0] node_char,
  input  logic [7:0] zone_char,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [1:0] cur_msg,
  output logic       msg_done,
  output logic       req_merged
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef UART_NULL_TERM_EN
  localparam int unsigned NT = 1;
`else
  localparam int unsigned NT = 0;
`endif

  localparam logic [1:0] T_ID   = 2'd0;
  localparam logic [1:0] T_PICK = 2'd1;
  localparam logic [1:0] T_DUMP = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SEND, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         pend_q, pend_d;
  logic [1:0]         rr_q, rr_d;
  logic [2:0][7:0]    node_slot_q, node_slot_d;
  logic [7:0]         zone_slot_q, zone_slot_d;
  logic [1:0]         snap_type_q, snap_type_d;
  logic [7:0]         snap_node_q, snap_node_d;
  logic [7:0]         snap_zone_q, snap_zone_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [7:0]         tx_data_d;
  logic               tx_valid_d, busy_d, msg_done_d, req_merged_d;
  logic [1:0]         cur_msg_d;
  logic [2:0]         req, clr, grant;

  // Byte i of message type t; bytes past '#' read as 8'h00 (null terminator).
  function automatic logic [7:0] msg_byte(input logic [1:0] t, input logic [7:0] n,
                                          input logic [7:0] z, input logic [3:0] i);
    logic [7:0] b;
    b = 8'h00;
    if (t == T_ID) begin
      case (i)
        4'd0: b = "G";  4'd1: b = "B";  4'd2: b = "I";  4'd3: b = UNIT_CHAR;
        4'd4: b = "-";  4'd5: b = n;    4'd6: b = "-";  4'd7: b = "#";
        default: b = 8'h00;
      endcase
    end else if (t == T_PICK) begin
      case (i)
        4'd0: b = "G";  4'd1: b = "B";  4'd2: b = UNIT_CHAR; 4'd3: b = "-";
        4'd4: b = n;    4'd5: b = "-";  4'd6: b = "P";  4'd7: b = "I";
        4'd8: b = "C";  4'd9: b = "K";  4'd10: b = "-"; 4'd11: b = "#";
        default: b = 8'h00;
      endcase
    end else begin
      case (i)
        4'd0: b = "G";  4'd1: b = "B";  4'd2: b = UNIT_CHAR; 4'd3: b = "-";
        4'd4: b = n;    4'd5: b = "-";  4'd6: b = z;    4'd7: b = "-";
        4'd8: b = "D";  4'd9: b = "U";  4'd10: b = "M"; 4'd11: b = "P";
        4'd12: b = "-"; 4'd13: b = "#";
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // Index of the final byte for message type t.
  function automatic logic [3:0] last_idx(input logic [1:0] t);
    case (t)
      T_ID:    return 4'(7 + NT);
      T_PICK:  return 4'(11 + NT);
      default: return 4'(13 + NT);
    endcase
  endfunction

  // Round-robin pick: {valid, type}, scanning from ptr and wrapping DUMP -> ID.
  function automatic logic [2:0] rr_grant(input logic [1:0] ptr, input logic [2:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    c   = ptr;
    for (int k = 0; k < 3; k++) begin
      if (!res[2] && p[c]) res = {1'b1, c};
      c = (c == T_DUMP) ? T_ID : c + 2'd1;
    end
    return res;
  endfunction

  assign req   = {dump_req, pick_req, id_req};
  assign grant = rr_grant(rr_q, pend_q);

  // Next-state, datapath and output logic.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    rr_d         = rr_q;
    node_slot_d  = node_slot_q;
    zone_slot_d  = zone_slot_q;
    snap_type_d  = snap_type_q;
    snap_node_d  = snap_node_q;
    snap_zone_d  = snap_zone_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    tx_data_d    = tx_data;
    tx_valid_d   = tx_valid;
    cur_msg_d    = cur_msg;
    msg_done_d   = 1'b0;
    req_merged_d = 1'b0;
    clr          = 3'b000;

    case (state_q)
      S_IDLE: if (|pend_q) state_d = S_ARB;
      S_ARB: begin
        if (grant[2]) begin
          clr[grant[1:0]] = 1'b1;
          snap_type_d     = grant[1:0];
          snap_node_d     = node_slot_q[grant[1:0]];
          snap_zone_d     = zone_slot_q;
          cur_msg_d       = grant[1:0] + 2'd1;
          rr_d            = (grant[1:0] == T_DUMP) ? T_ID : grant[1:0] + 2'd1;
          idx_d           = '0;
          tx_data_d       = msg_byte(grant[1:0], node_slot_q[grant[1:0]], zone_slot_q, 4'd0);
          tx_valid_d      = 1'b1;
          state_d         = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (tx_valid && tx_ready) begin
          if (idx_q == last_idx(snap_type_q)) begin
            idx_d      = '0;
            cur_msg_d  = 2'd0;
            msg_done_d = 1'b1;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            gap_d      = '0;
            state_d    = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = msg_byte(snap_type_q, snap_node_q, snap_zone_q, idx_q + 4'd1);
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else                                 gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Request capture; a grant clearing the same type this cycle is not a merge.
    pend_d = pend_q & ~clr;
    for (int t = 0; t < 3; t++) begin
      if (req[t]) begin
        if (pend_q[t] && !clr[t]) req_merged_d = 1'b1;
        pend_d[t]      = 1'b1;
        node_slot_d[t] = node_char;
      end
    end
    if (dump_req) zone_slot_d = zone_char;

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      rr_q        <= T_ID;
      node_slot_q <= '0;
      zone_slot_q <= '0;
      snap_type_q <= T_ID;
      snap_node_q <= '0;
      snap_zone_q <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      cur_msg     <= '0;
      msg_done    <= 1'b0;
      req_merged  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rr_q        <= rr_d;
      node_slot_q <= node_slot_d;
      zone_slot_q <= zone_slot_d;
      snap_type_q <= snap_type_d;
      snap_node_q <= snap_node_d;
      snap_zone_q <= snap_zone_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      tx_data     <= tx_data_d;
      tx_valid    <= tx_valid_d;
      busy        <= busy_d;
      cur_msg     <= cur_msg_d;
      msg_done    <= msg_done_d;
      req_merged  <= req_merged_d;
    end
  end

endmodule
